// File: rtl/step_pulse_gen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_pulse_gen_pkg: state encodings and default parameter values  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package step_pulse_gen_pkg;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_PRESS_WAIT   = 3'd1,
      S_HELD         = 3'd2,
      S_REPEAT       = 3'd3,
      S_RELEASE_WAIT = 3'd4
   } state_t;

   localparam int unsigned c_DEF_DEBOUNCE = 4;
   localparam int unsigned c_DEF_HOLD     = 16;
   localparam int unsigned c_DEF_RATE     = 8;
   localparam int unsigned c_DEF_CW       = 8;

endpackage : step_pulse_gen_pkg
`default_nettype wire

// File: rtl/step_pulse_gen_sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_2ff: two-flop synchronizer, synchronous active-low clear     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sync_2ff (
   input  logic clk,
   input  logic clear,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_pulse_gen: debounced push-button to one-cycle step pulses    |
// | with optional auto-repeat.  Rev 1.0                               |
// +------------------------------------------------------------------+
module step_pulse_gen
   import step_pulse_gen_pkg::*;
#(
   parameter int unsigned DEBOUNCE = c_DEF_DEBOUNCE,
   parameter int unsigned HOLD     = c_DEF_HOLD,
   parameter int unsigned RATE     = c_DEF_RATE,
   parameter int unsigned CW       = c_DEF_CW
) (
   input  logic clk,
   input  logic clear,
   input  logic btn_in,
   output logic step,
   output logic level
);

   localparam logic [CW-1:0] c_CNT_ZERO = '0;
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] c_CNT_MAX  = '1;
   localparam logic [CW-1:0] c_DEB_LAST = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] c_HLD_LAST = CW'(HOLD - 1);
   localparam logic [CW-1:0] c_RPT_LAST = CW'(RATE - 1);
   localparam bit            c_RPT_EN   = (HOLD != 0);

   logic          w_s;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_step;
   logic          w_step_nxt;
   logic          r_level;
   logic          w_level_nxt;

   sync_2ff u_sync (
      .clk   (clk),
      .clear (clear),
      .i_d   (btn_in),
      .o_q   (w_s)
   );

   always_ff @(posedge clk) begin
      if (!clear) begin
         r_state <= S_IDLE;
         r_cnt   <= c_CNT_ZERO;
         r_step  <= 1'b0;
         r_level <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_step  <= w_step_nxt;
         r_level <= w_level_nxt;
      end
   end

   // A low synchronized input always wins over timer expiry in HELD/REPEAT.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_step_nxt  = 1'b0;
      w_level_nxt = r_level;

      unique case (r_state)
         S_IDLE: begin
            if (w_s) begin
               w_state_nxt = S_PRESS_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end

         S_PRESS_WAIT: begin
            if (!w_s) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = c_CNT_ZERO;
            end else if (r_cnt == c_DEB_LAST) begin
               w_state_nxt = S_HELD;
               w_step_nxt  = 1'b1;
               w_level_nxt = 1'b1;
               w_cnt_nxt   = c_CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end

         S_HELD: begin
            if (!w_s) begin
               w_state_nxt = S_RELEASE_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end else if (c_RPT_EN && (r_cnt == c_HLD_LAST)) begin
               w_state_nxt = S_REPEAT;
               w_step_nxt  = 1'b1;
               w_cnt_nxt   = c_CNT_ZERO;
            end else if (r_cnt != c_CNT_MAX) begin
               // Saturate so a very long hold with repeat disabled never wraps.
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end

         S_REPEAT: begin
            if (!w_s) begin
               w_state_nxt = S_RELEASE_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end else if (r_cnt == c_RPT_LAST) begin
               w_step_nxt  = 1'b1;
               w_cnt_nxt   = c_CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end

         S_RELEASE_WAIT: begin
            if (w_s) begin
               // Release bounce: back to HELD silently, hold timer restarts.
               w_state_nxt = S_HELD;
               w_cnt_nxt   = c_CNT_ZERO;
            end else if (r_cnt == c_DEB_LAST) begin
               w_state_nxt = S_IDLE;
               w_level_nxt = 1'b0;
               w_cnt_nxt   = c_CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = c_CNT_ZERO;
            w_level_nxt = 1'b0;
         end
      endcase
   end

   assign step  = r_step;
   assign level = r_level;

endmodule : step_pulse_gen
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_step_pulse_gen: scoreboard bench, default DUT plus HOLD=0 DUT  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_step_pulse_gen;

   localparam int c_DEB  = 4;
   localparam int c_HOLD = 16;
   localparam int c_RATE = 8;

   typedef struct {
      int   e;
      logic v;
   } lev_t;

   logic clk    = 1'b0;
   logic clear  = 1'b0;
   logic btn_in = 1'b1;
   logic step_a, level_a, step_b, level_b;

   int   edge_n = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   pa     = 0;
   int   pb     = 0;

   int   qa_step[$];
   int   qb_step[$];
   lev_t qa_lev[$];
   lev_t qb_lev[$];

   logic       prev_step_a = 1'b0, prev_lvl_a = 1'b0;
   logic       prev_step_b = 1'b0, prev_lvl_b = 1'b0;
   logic [2:0] cnt3_a, cnt3_b;
   int         ia_tmp, ib_tmp;
   lev_t       la_tmp, lb_tmp;

   step_pulse_gen #(.DEBOUNCE(c_DEB), .HOLD(c_HOLD), .RATE(c_RATE), .CW(8)) u_dut_a (
      .clk    (clk),
      .clear  (clear),
      .btn_in (btn_in),
      .step   (step_a),
      .level  (level_a)
   );

   step_pulse_gen #(.DEBOUNCE(c_DEB), .HOLD(0), .RATE(c_RATE), .CW(8)) u_dut_b (
      .clk    (clk),
      .clear  (clear),
      .btn_in (btn_in),
      .step   (step_b),
      .level  (level_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n = edge_n + 1;

   // Downstream 3-bit counters enabled by step.
   always @(posedge clk) begin
      if (!clear) begin
         cnt3_a <= 3'd0;
         cnt3_b <= 3'd0;
      end else begin
         if (step_a) cnt3_a <= cnt3_a + 3'd1;
         if (step_b) cnt3_b <= cnt3_b + 3'd1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Monitors: pop an expectation whenever a DUT presents a pulse or level change.
   always @(negedge clk) begin
      if (step_a === 1'b1) begin
         check("A step back-to-back", int'(prev_step_a), 0);
         if (qa_step.size() == 0) check("A step unexpected", edge_n, -1);
         else begin
            ia_tmp = qa_step.pop_front();
            check("A step edge", edge_n, ia_tmp);
         end
      end
      while (qa_step.size() > 0 && qa_step[0] < edge_n) begin
         ia_tmp = qa_step.pop_front();
         check("A step missing", edge_n, ia_tmp);
      end
      if (level_a !== prev_lvl_a) begin
         if (qa_lev.size() == 0) check("A level unexpected", edge_n, -1);
         else begin
            la_tmp = qa_lev.pop_front();
            check("A level edge", edge_n, la_tmp.e);
            check("A level value", int'(level_a === 1'b1), int'(la_tmp.v));
         end
      end
      while (qa_lev.size() > 0 && qa_lev[0].e < edge_n) begin
         la_tmp = qa_lev.pop_front();
         check("A level missing", edge_n, la_tmp.e);
      end
      prev_step_a = step_a;
      prev_lvl_a  = level_a;
   end

   always @(negedge clk) begin
      if (step_b === 1'b1) begin
         check("B step back-to-back", int'(prev_step_b), 0);
         if (qb_step.size() == 0) check("B step unexpected", edge_n, -1);
         else begin
            ib_tmp = qb_step.pop_front();
            check("B step edge", edge_n, ib_tmp);
         end
      end
      while (qb_step.size() > 0 && qb_step[0] < edge_n) begin
         ib_tmp = qb_step.pop_front();
         check("B step missing", edge_n, ib_tmp);
      end
      if (level_b !== prev_lvl_b) begin
         if (qb_lev.size() == 0) check("B level unexpected", edge_n, -1);
         else begin
            lb_tmp = qb_lev.pop_front();
            check("B level edge", edge_n, lb_tmp.e);
            check("B level value", int'(level_b === 1'b1), int'(lb_tmp.v));
         end
      end
      while (qb_lev.size() > 0 && qb_lev[0].e < edge_n) begin
         lb_tmp = qb_lev.pop_front();
         check("B level missing", edge_n, lb_tmp.e);
      end
      prev_step_b = step_b;
      prev_lvl_b  = level_b;
   end

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         btn_in = v;
      end
   endtask

   task automatic push_press(input int t0, input int tfall);
      lev_t r, f;
      r.e = t0;    r.v = 1'b1;
      f.e = tfall; f.v = 1'b0;
      qa_step.push_back(t0);
      qb_step.push_back(t0);
      pa++;
      pb++;
      qa_lev.push_back(r);
      qa_lev.push_back(f);
      qb_lev.push_back(r);
      qb_lev.push_back(f);
   endtask

   // Clean press held for h sampled edges starting at edge k, then release.
   task automatic press(input int h);
      int k, t0, t;
      k = edge_n + 2;
      if (h >= c_DEB) begin
         t0 = k + 1 + c_DEB;
         push_press(t0, k + h + 1 + c_DEB);
         t = t0 + c_HOLD;
         while (t <= k + h + 1) begin
            qa_step.push_back(t);
            pa++;
            t = t + c_RATE;
         end
      end
      drive(1'b1, h);
      drive(1'b0, 12);
   endtask

   task automatic check_counters(input string tag);
      check({tag, " counter A"}, int'(cnt3_a), pa % 8);
      check({tag, " counter B"}, int'(cnt3_b), pb % 8);
   endtask

   initial begin
      int k;
      // Reset held for 3 edges with the button pressed.
      repeat (3) begin
         @(negedge clk);
         check("reset step A", int'(step_a === 1'b1), 0);
         check("reset level A", int'(level_a === 1'b1), 0);
         check("reset step B", int'(step_b === 1'b1), 0);
         check("reset level B", int'(level_b === 1'b1), 0);
      end
      clear = 1'b1;
      k = edge_n + 1;
      push_press(k + 5, k + 10 + 5);
      drive(1'b1, 9);
      drive(1'b0, 12);
      check_counters("after reset");

      press(10);
      check_counters("clean press");

      // Press bounce 1,0,1,0 then hold; release bounce 0,1 then stable low.
      k = edge_n + 2;
      push_press(k + 9, k + 23);
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 12);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 14);
      check_counters("bounce");

      press(3);
      check_counters("short glitch");
      press(4);
      check_counters("debounce boundary");

      press(60);
      check_counters("auto-repeat");

      press(19);
      check_counters("release priority");
      press(20);
      check_counters("first repeat boundary");

      drive(1'b0, 10);
      check("A steps outstanding", qa_step.size(), 0);
      check("B steps outstanding", qb_step.size(), 0);
      check("A levels outstanding", qa_lev.size(), 0);
      check("B levels outstanding", qb_lev.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_step_pulse_gen
`default_nettype wire
